hour_mode_counter: RTL and testbench
====================================

// Module: hour_mode_counter
// PURPOSE
//  BCD time-of-day core for myClock: second prescaler plus sec/min/hour BCD counters,
//  with a registered 24h->12h display path and PM flag selected at run time by Trans.
//  Supersedes the combinational 24h/12h converter. Sits between the board clock and the
//  7-segment/LED display drivers; the set-time logic drives its load port.
// PARAMETERS
//  DIV        50_000_000  CP cycles per one-second Tick (>=2)
//  DIV_W      26          prescaler width; 2**DIV_W >= DIV
// PORTS
//  CP        in   1  system clock, rising edge
//  nCR       in   1  asynchronous active-low reset (clear)
//  En        in   1  count enable; low freezes prescaler and time counters
//  Trans     in   1  display mode: 1 = 12h, 0 = 24h
//  Load      in   1  one-cycle strobe: load LoadHour/LoadMin/LoadSec
//  LoadHour  in   8  BCD hour, 00..23
//  LoadMin   in   8  BCD minute, 00..59
//  LoadSec   in   8  BCD second, 00..59
//  Hour24    out  8  BCD hour counter, 24h
//  Min       out  8  BCD minute counter
//  Sec       out  8  BCD second counter
//  HourDisp  out  8  BCD display hour (12h or 24h per Trans), registered
//  PM        out  1  1 = PM (12h mode only; 0 in 24h mode), registered
//  Tick      out  1  one-cycle pulse when a second elapses
//  LoadErr   out  1  one-cycle pulse: Load rejected (invalid BCD)
//  Chime     out  1  hourly chime window (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (nCR=0, async): prescaler=0; Hour24/Min/Sec=8'h00; HourDisp=8'h00; PM=0;
//    Tick=0; LoadErr=0; Chime=0. Asserting nCR mid-count clears immediately.
//  - Prescaler: when En=1 counts 0..DIV-1; Tick registered high in the cycle after it
//    reaches DIV-1, then it wraps to 0. En=0 holds the count and drives Tick=0.
//  - Time update on the Tick cycle: Sec +1 BCD (low digit 9->0 carries to high digit);
//    Sec 59->00 increments Min; Min 59->00 increments Hour24; 23:59:59 -> 00:00:00.
//    All three counters update in the same cycle (no ripple delay).
//  - Load (priority over Tick and En): all fields valid (each digit<=9, hour<=0x23,
//    min/sec<=0x59) -> counters take load values next edge, prescaler cleared to 0,
//    any coincident Tick increment is discarded. Any field invalid -> nothing changes,
//    LoadErr=1 for one cycle; prescaler keeps running.
//  - Display path, one-cycle latency from Hour24 or Trans change:
//    Trans=0: HourDisp=Hour24, PM=0.
//    Trans=1: 00->12,PM=0; 01..11->same,PM=0; 12->12,PM=1; 13..23->Hour24-12 in BCD
//    (13->01 ... 19->07, 20->08, 21->09, 22->10, 23->11), PM=1.
//    BCD subtraction handles the decade borrow (0x20-12 = 0x08, not 0x0E).
//  - Trans may toggle on any cycle; counters are unaffected, only HourDisp/PM follow.
// CONFIGURATION
//  CHIME_EN defined: Chime registered high while Min==8'h59 and Sec>=8'h55
//    (five seconds before each hour, 24h counter values, independent of Trans),
//    cleared on the edge Sec becomes 00; also cleared by Load and nCR.
//  CHIME_EN undefined: chime logic absent; Chime tied 0.
// TESTING  (bench uses DIV=4)
//  1 Reset: nCR=0 mid-count -> all outputs 0 at once; release -> first Tick 4 cycles later
//  2 Load 23:59:58, En=1 -> after 2 Ticks 00:00:00; HourDisp 8'h00 (24h),
//    Trans=1 -> HourDisp 8'h12, PM=0 next cycle
//  3 Sweep Load hour 00..23 with Trans=1 -> HourDisp/PM match the table, incl. 20->08 PM
//  4 Load 8'h24 hour or 8'h5A sec -> LoadErr pulse, counters unchanged
//  5 Load in same cycle as Tick -> loaded value kept exactly, no +1; En=0 -> time frozen
//  6 CHIME_EN: Load 10:59:54 -> Chime rises at :55, falls when time is 11:00:00;
//    without macro Chime stays 0

Source files
------------

// File: rtl/hour_mode_counter.sv
// rtl/hour_mode_counter.sv - BCD time-of-day core with 12h/24h registered display path
// Optional hourly chime window enabled by defining CHIME_EN.
module hour_mode_counter #(
    parameter int DIV   = 50_000_000,
    parameter int DIV_W = 26
) (
    input  logic       CP,
    input  logic       nCR,
    input  logic       En,
    input  logic       Trans,
    input  logic       Load,
    input  logic [7:0] LoadHour,
    input  logic [7:0] LoadMin,
    input  logic [7:0] LoadSec,
    output logic [7:0] Hour24,
    output logic [7:0] Min,
    output logic [7:0] Sec,
    output logic [7:0] HourDisp,
    output logic       PM,
    output logic       Tick,
    output logic       LoadErr,
    output logic       Chime
);

    logic [DIV_W-1:0] r_presc;
    logic [7:0]       r_hour, r_min, r_sec;
    logic [7:0]       r_hdisp;
    logic             r_pm, r_tick, r_load_err;

    logic             w_tick_now, w_load_ok, w_load_acc, w_load_rej;
    logic             w_sec_wrap, w_min_wrap, w_hour_wrap;
    logic [7:0]       w_sec_inc, w_min_inc, w_hour_inc;
    logic [7:0]       w_hour_nx, w_min_nx, w_sec_nx;
    logic [4:0]       w_hour_bin, w_pm_bin;
    logic [7:0]       w_pm_bcd;
    logic [7:0]       w_hdisp_nx;
    logic             w_pm_nx;

    assign w_tick_now = En && (r_presc == DIV_W'(DIV - 1));

    assign w_load_ok  = (LoadHour[3:0] <= 4'd9) && (LoadHour <= 8'h23) &&
                        (LoadMin[7:4]  <= 4'd5) && (LoadMin[3:0] <= 4'd9) &&
                        (LoadSec[7:4]  <= 4'd5) && (LoadSec[3:0] <= 4'd9);
    assign w_load_acc = Load && w_load_ok;
    assign w_load_rej = Load && !w_load_ok;

    assign w_sec_wrap  = (r_sec  == 8'h59);
    assign w_min_wrap  = (r_min  == 8'h59);
    assign w_hour_wrap = (r_hour == 8'h23);

    assign w_sec_inc  = w_sec_wrap  ? 8'h00 :
                        (r_sec[3:0]  == 4'd9) ? {r_sec[7:4]  + 4'd1, 4'd0} : r_sec  + 8'd1;
    assign w_min_inc  = w_min_wrap  ? 8'h00 :
                        (r_min[3:0]  == 4'd9) ? {r_min[7:4]  + 4'd1, 4'd0} : r_min  + 8'd1;
    assign w_hour_inc = w_hour_wrap ? 8'h00 :
                        (r_hour[3:0] == 4'd9) ? {r_hour[7:4] + 4'd1, 4'd0} : r_hour + 8'd1;

    // All three fields resolve from the current state so they move on the same edge.
    always_comb begin
        w_hour_nx = r_hour;
        w_min_nx  = r_min;
        w_sec_nx  = r_sec;
        if (w_load_acc) begin
            w_hour_nx = LoadHour;
            w_min_nx  = LoadMin;
            w_sec_nx  = LoadSec;
        end else if (w_tick_now) begin
            w_sec_nx = w_sec_inc;
            if (w_sec_wrap) begin
                w_min_nx = w_min_inc;
                if (w_min_wrap) begin
                    w_hour_nx = w_hour_inc;
                end
            end
        end
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            r_presc    <= '0;
            r_hour     <= 8'h00;
            r_min      <= 8'h00;
            r_sec      <= 8'h00;
            r_tick     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_hour     <= w_hour_nx;
            r_min      <= w_min_nx;
            r_sec      <= w_sec_nx;
            r_tick     <= w_tick_now && !w_load_acc;
            r_load_err <= w_load_rej;
            if (w_load_acc) begin
                r_presc <= '0;
            end else if (En) begin
                r_presc <= w_tick_now ? '0 : r_presc + DIV_W'(1);
            end
        end
    end

    // Afternoon hours go through binary so the decade borrow (20 -> 08) comes out right.
    assign w_hour_bin = 5'(r_hour[7:4]) * 5'd10 + 5'(r_hour[3:0]);
    assign w_pm_bin   = w_hour_bin - 5'd12;
    assign w_pm_bcd   = (w_pm_bin >= 5'd10) ? {4'd1, 4'(w_pm_bin - 5'd10)}
                                            : {4'd0, 4'(w_pm_bin)};

    always_comb begin
        w_hdisp_nx = r_hour;
        w_pm_nx    = 1'b0;
        if (Trans) begin
            if (r_hour == 8'h00) begin
                w_hdisp_nx = 8'h12;
            end else if (r_hour == 8'h12) begin
                w_pm_nx = 1'b1;
            end else if (r_hour > 8'h12) begin
                w_hdisp_nx = w_pm_bcd;
                w_pm_nx    = 1'b1;
            end
        end
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            r_hdisp <= 8'h00;
            r_pm    <= 1'b0;
        end else begin
            r_hdisp <= w_hdisp_nx;
            r_pm    <= w_pm_nx;
        end
    end

`ifdef CHIME_EN
    logic r_chime;

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            r_chime <= 1'b0;
        end else if (w_load_acc) begin
            r_chime <= 1'b0;
        end else begin
            r_chime <= (w_min_nx == 8'h59) && (w_sec_nx >= 8'h55);
        end
    end

    assign Chime = r_chime;
`else
    assign Chime = 1'b0;
`endif

    assign Hour24   = r_hour;
    assign Min      = r_min;
    assign Sec      = r_sec;
    assign HourDisp = r_hdisp;
    assign PM       = r_pm;
    assign Tick     = r_tick;
    assign LoadErr  = r_load_err;

endmodule

// File: tb/tb_hour_mode_counter.sv
// tb/tb_hour_mode_counter.sv - scoreboard bench for hour_mode_counter (DIV=4)
module tb_hour_mode_counter;

    logic       CP = 1'b0;
    logic       nCR = 1'b0;
    logic       En = 1'b0;
    logic       Trans = 1'b0;
    logic       Load = 1'b0;
    logic [7:0] LoadHour = 8'h00;
    logic [7:0] LoadMin = 8'h00;
    logic [7:0] LoadSec = 8'h00;
    logic [7:0] Hour24, Min, Sec, HourDisp;
    logic       PM, Tick, LoadErr, Chime;

    hour_mode_counter #(.DIV(4), .DIV_W(3)) dut (
        .CP(CP), .nCR(nCR), .En(En), .Trans(Trans), .Load(Load),
        .LoadHour(LoadHour), .LoadMin(LoadMin), .LoadSec(LoadSec),
        .Hour24(Hour24), .Min(Min), .Sec(Sec), .HourDisp(HourDisp),
        .PM(PM), .Tick(Tick), .LoadErr(LoadErr), .Chime(Chime)
    );

    always #5 CP = ~CP;

`ifdef CHIME_EN
    localparam logic CH = 1'b1;
`else
    localparam logic CH = 1'b0;
`endif

    typedef struct packed {logic [7:0] h, m, s; logic ch;} tick_t;
    typedef struct packed {logic [7:0] h, m, s, d; logic pm, ch;} probe_t;

    tick_t       q_tick[$];
    logic [23:0] q_err[$];
    probe_t      q_probe[$];

    int   n_checks = 0;
    int   n_errors = 0;
    logic probe = 1'b0;
    logic tick_dc = 1'b0;

    tick_t  mt;
    probe_t mp;
    logic [23:0] me;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    always @(negedge CP) begin
        if (Tick && !tick_dc) begin
            if (q_tick.size() == 0) begin
                check("unexpected_tick", {Hour24, Min, Sec}, 64'hFFFFFF);
            end else begin
                mt = q_tick.pop_front();
                check("tick_time", {Hour24, Min, Sec, 7'd0, Chime}, {mt.h, mt.m, mt.s, 7'd0, mt.ch});
            end
        end
        if (LoadErr) begin
            if (q_err.size() == 0) begin
                check("unexpected_loaderr", {Hour24, Min, Sec}, 64'hFFFFFF);
            end else begin
                me = q_err.pop_front();
                check("loaderr_time", {Hour24, Min, Sec}, me);
            end
        end
        if (probe) begin
            mp = q_probe.pop_front();
            check("probe", {Hour24, Min, Sec, HourDisp, 7'd0, PM, 7'd0, Chime},
                  {mp.h, mp.m, mp.s, mp.d, 7'd0, mp.pm, 7'd0, mp.ch});
        end
    end

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        Load = 1'b1; LoadHour = h; LoadMin = m; LoadSec = s;
        @(posedge CP); #1;
        Load = 1'b0;
    endtask

    task automatic probe_exp(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                             input logic [7:0] d, input logic pm, input logic ch);
        q_probe.push_back('{h: h, m: m, s: s, d: d, pm: pm, ch: ch});
        probe = 1'b1;
        @(posedge CP); #1;
        probe = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 40 * n) begin
            @(negedge CP);
            cyc++;
            if (Tick) got++;
        end
        if (got < n) check("tick_timeout", 64'(got), 64'(n));
        @(posedge CP); #1;
    endtask

    logic [7:0] hours [24] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                               8'h08, 8'h09, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
                               8'h16, 8'h17, 8'h18, 8'h19, 8'h20, 8'h21, 8'h22, 8'h23};
    logic [7:0] disp12 [24] = '{8'h12, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                8'h08, 8'h09, 8'h10, 8'h11, 8'h12, 8'h01, 8'h02, 8'h03,
                                8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h10, 8'h11};

    initial begin
        int n;
        repeat (3) @(posedge CP);
        #1;
        probe_exp(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        // Release and time the first Tick.
        q_tick.push_back('{h: 8'h00, m: 8'h00, s: 8'h01, ch: 1'b0});
        nCR = 1'b1; En = 1'b1;
        n = 0;
        while (n < 20) begin
            @(posedge CP);
            n++;
            @(negedge CP);
            if (Tick) break;
        end
        check("first_tick_latency", 64'(n), 64'd4);
        @(posedge CP); #1;

        // Mid-count asynchronous clear.
        nCR = 1'b0; En = 1'b0;
        probe_exp(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        @(posedge CP); #1;
        nCR = 1'b1;

        // Midnight rollover and 12h view of hour 00.
        do_load(8'h23, 8'h59, 8'h58);
        q_tick.push_back('{h: 8'h23, m: 8'h59, s: 8'h59, ch: CH});
        q_tick.push_back('{h: 8'h00, m: 8'h00, s: 8'h00, ch: 1'b0});
        En = 1'b1;
        wait_ticks(2);
        En = 1'b0;
        probe_exp(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        Trans = 1'b1;
        @(posedge CP); #1;
        probe_exp(8'h00, 8'h00, 8'h00, 8'h12, 1'b0, 1'b0);

        // Hour sweep in 12h mode.
        for (int i = 0; i < 24; i++) begin
            do_load(hours[i], 8'h30, 8'h15);
            @(posedge CP); #1;
            probe_exp(hours[i], 8'h30, 8'h15, disp12[i], (i >= 12), 1'b0);
        end

        // Rejected loads leave the time alone.
        repeat (4) q_err.push_back({8'h23, 8'h30, 8'h15});
        do_load(8'h24, 8'h00, 8'h00);
        do_load(8'h10, 8'h10, 8'h5A);
        do_load(8'h1A, 8'h00, 8'h00);
        do_load(8'h10, 8'h60, 8'h00);
        probe_exp(8'h23, 8'h30, 8'h15, 8'h11, 1'b1, 1'b0);

        // Load on the same edge as a Tick, then freeze.
        En = 1'b1;
        do_load(8'h08, 8'h15, 8'h30);
        repeat (3) @(posedge CP);
        #1;
        tick_dc = 1'b1;
        do_load(8'h12, 8'h00, 8'h00);
        probe_exp(8'h12, 8'h00, 8'h00, 8'h08, 1'b0, 1'b0);
        tick_dc = 1'b0;
        q_tick.push_back('{h: 8'h12, m: 8'h00, s: 8'h01, ch: 1'b0});
        wait_ticks(1);
        En = 1'b0;
        repeat (8) @(posedge CP);
        #1;
        probe_exp(8'h12, 8'h00, 8'h01, 8'h12, 1'b1, 1'b0);

        // Chime window across the top of the hour.
        Trans = 1'b0; En = 1'b1;
        q_tick.push_back('{h: 8'h10, m: 8'h59, s: 8'h55, ch: CH});
        q_tick.push_back('{h: 8'h10, m: 8'h59, s: 8'h56, ch: CH});
        q_tick.push_back('{h: 8'h10, m: 8'h59, s: 8'h57, ch: CH});
        q_tick.push_back('{h: 8'h10, m: 8'h59, s: 8'h58, ch: CH});
        q_tick.push_back('{h: 8'h10, m: 8'h59, s: 8'h59, ch: CH});
        q_tick.push_back('{h: 8'h11, m: 8'h00, s: 8'h00, ch: 1'b0});
        do_load(8'h10, 8'h59, 8'h54);
        probe_exp(8'h10, 8'h59, 8'h54, 8'h12, 1'b0, 1'b0);
        wait_ticks(6);
        En = 1'b0;
        probe_exp(8'h11, 8'h00, 8'h00, 8'h11, 1'b0, 1'b0);

        repeat (4) @(posedge CP);
        check("tick_queue_drained", 64'(q_tick.size()), 64'd0);
        check("err_queue_drained", 64'(q_err.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
